// File: rtl/arith_pkg.sv
// ----------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the arithmetic library.
//   ARITH_W  default operand width for the serial arithmetic blocks
//   state_e  controller state encoding (IDLE / RUN / DONE)
// ----------------------------------------------------------------------------
package arith_pkg;

   localparam int ARITH_W = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

endpackage : arith_pkg

// File: rtl/full_subtractor.sv
// ----------------------------------------------------------------------------
// full_subtractor
// 1-bit combinational full subtractor. It is the borrow dual of the 1-bit
// full adder: d = a - b - bin, with the borrow out in bout.
// Ports:
//   a     in   minuend bit
//   b     in   subtrahend bit
//   bin   in   borrow in
//   d     out  difference bit
//   bout  out  borrow out
// ----------------------------------------------------------------------------
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   // A borrow is needed when b exceeds a outright, or when they are equal
   // and a borrow is already pending.
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor: d = a - b - bin (mod 2^WIDTH), one bit per
// clock, LSB first, using a single full_subtractor cell and a borrow flop.
// A start pulse in IDLE or DONE captures the operands; busy is high for WIDTH
// cycles, then done pulses for one cycle while d/bout show the new result.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-high
//   start  in   request pulse; a, b and bin are sampled on the same edge
//   a      in   minuend   [WIDTH]
//   b      in   subtrahend [WIDTH]
//   bin    in   borrow in
//   busy   out  subtraction in progress
//   done   out  one-cycle pulse when d/bout have just been updated
//   d      out  difference, registered [WIDTH]
//   bout   out  borrow out of the MSB, registered
// ----------------------------------------------------------------------------
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int WIDTH = ARITH_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_e           state_q,  state_d;
   logic [WIDTH-1:0] a_sh_q,   a_sh_d;
   logic [WIDTH-1:0] b_sh_q,   b_sh_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic [WIDTH-1:0] d_q,      d_d;
   logic             br_q,     br_d;
   logic             bout_q,   bout_d;
   logic [CW-1:0]    cnt_q,    cnt_d;

   logic di;
   logic br_next;

   full_subtractor u_fs (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .bin  (br_q),
      .d    (di),
      .bout (br_next)
   );

   // NOTE: every signal written here gets its hold value first, so no path
   // through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      d_d      = d_q;
      br_d     = br_q;
      bout_d   = bout_q;
      cnt_d    = cnt_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            // DONE accepts start too, giving back-to-back operation.
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               br_d    = bin;
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            br_d     = br_next;
            // Entering from the MSB side: after WIDTH shifts the first
            // (LSB) difference bit has arrived at bit 0.
            res_sh_d = {di, res_sh_q[WIDTH-1:1]};
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               d_d     = {di, res_sh_q[WIDTH-1:1]};
               bout_d  = br_next;
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         d_q      <= '0;
         br_q     <= 1'b0;
         bout_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         d_q      <= d_d;
         br_q     <= br_d;
         bout_q   <= bout_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign d    = d_q;
   assign bout = bout_q;

endmodule : serial_subtractor

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing d = a - b - bin, one bit per clock, LSB first.
- Uses a single 1-bit full-subtractor cell and a registered borrow.
- Sits beside the ripple adders in the arithmetic library as the subtract direction.
- Trades latency for area; has a start/busy/done handshake for use by sequential datapath controllers.

Parameters:
- WIDTH, 4, operand and result width in bits; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request pulse; operands are sampled on the same edge.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in; sampled with start.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse when d/bout are updated.
- d  output  WIDTH  difference, registered.
- bout  output  1  borrow-out from the MSB, registered.

Behaviour:
- Clocking/reset: single clock clk; reset rst is synchronous and active-high.
- On a rst edge: state=IDLE; busy=0, done=0, d=0, bout=0; all internal shift registers, borrow flop and bit counter are cleared.
- rst mid-operation aborts the operation: no done pulse, and d/bout read 0.
- States:
  - IDLE: busy=0, done=0.
    - start=1 -> capture a, b into shift registers and bin into the borrow flop; cnt=0; go to RUN.
    - start=0 -> stay in IDLE.
  - RUN: busy=1. Each edge:
    - di = ai ^ bi ^ br.
    - br' = (~ai & bi) | (~(ai ^ bi) & br), where ai/bi are the current LSBs.
    - Shift di into the result shift register from the MSB side; shift the operand registers right; cnt++.
    - On the edge where cnt==WIDTH-1: load d with the completed result, load bout with the final br'; done=1 next cycle; go to DONE.
    - start is ignored in RUN; operands do not change.
  - DONE: busy=0, done=1 for exactly this cycle.
    - start=1 -> capture new operands and go to RUN (back-to-back, no idle bubble).
    - start=0 -> go to IDLE.
- Latency: with start sampled at edge E0, done is high in the cycle after edge E0+WIDTH. Initiation interval is WIDTH+1 cycles.
- d/bout hold their last result until the next completion. They are not disturbed while a new operation is in RUN.
- Arithmetic:
  - Modulo 2^WIDTH.
  - bout=1 iff a < b + bin (unsigned).
  - Signed overflow is not reported.
- Counter width: $clog2(WIDTH). No wrap beyond WIDTH-1 is reachable.
- done and busy are never high together.

Decomposition:
- Shared package arith_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - the default width constant ARITH_W=4.
- One sub-module, full_subtractor (a, b, bin -> d, bout), combinational. It is the borrow dual of the existing 1-bit full adder, and is instantiated once.
- FSM, counter and shift registers stay in serial_subtractor.

Test Plan:
- a=4'd7, b=4'd3, bin=0, start pulse -> busy high 4 cycles; done pulse; d=4'd4, bout=0.
- a=4'd3, b=4'd5, bin=0 -> d=4'b1110 (14), bout=1. a=4'd0, b=4'd0, bin=1 -> d=4'd15, bout=1.
- start re-asserted with a=4'd9 during RUN of a=4'd8, b=4'd1 -> ignored; result d=4'd7, exactly one done pulse.
- start asserted in the DONE cycle with a=4'd12, b=4'd12 -> RUN entered next edge. The first result remains readable until the second done pulse, which shows d=0, bout=0.
- rst asserted on the 2nd RUN cycle -> next cycle busy=0, done=0, d=0, bout=0, state IDLE. No done pulse follows. A subsequent start with a=4'd5, b=4'd2 gives d=4'd3.
- Exhaustive sweep, WIDTH=4: all a, b, bin combinations checked against {bout,d} = {1'b0,a} - {1'b0,b} - bin. Repeat a random sweep with WIDTH=8.
